// File: rtl/tx_selio_pkg.sv
// tx_selio_pkg: register map, bit positions and serializer state encoding
package tx_selio_pkg;
  localparam int WORD_W = 32;
  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_TXDATA = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h8;
  localparam logic [3:0] ADDR_COUNT  = 4'hC;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_LOOP     = 1;
  localparam int STAT_BUSY     = 0;
  localparam int STAT_PEND     = 1;
  localparam int STAT_UNDERRUN = 2;
  localparam int STAT_OVERRUN  = 3;
  typedef enum logic {S_IDLE, S_SHIFT} state_t;
endpackage

// File: rtl/tx_selio_ser.sv
// tx_selio_ser: 32-bit MSB-first serializer with gapless reload and word counter
module tx_selio_ser
  import tx_selio_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic              loop,
  input  logic              pend,
  input  logic [WORD_W-1:0] hold,
  output logic              take,
  output logic              busy,
  output logic              underrun_set,
  output logic [WORD_W-1:0] count,
  output logic              sdata,
  output logic              valid,
  output logic              frame
);
  state_t state;
  logic [4:0] bit_cnt;
  logic [WORD_W-1:0] sh, last;
  logic last_bit, relo;
  assign busy = state == S_SHIFT;
  assign last_bit = busy && bit_cnt == 5'd0;
  assign take = en & pend & (~busy | last_bit);
  assign relo = last_bit & en & ~pend & loop;
  assign underrun_set = last_bit & en & ~pend & ~loop;
  assign sdata = busy & sh[WORD_W-1];
  assign valid = busy;
  assign frame = busy && bit_cnt == 5'd31;
  // last keeps the unshifted word so loop mode can replay it
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      bit_cnt <= '0;
      sh <= '0;
      last <= '0;
      count <= '0;
    end else if (take) begin
      state <= S_SHIFT;
      sh <= hold;
      last <= hold;
      bit_cnt <= 5'd31;
      count <= count + 32'd1;
    end else if (relo) begin
      sh <= last;
      bit_cnt <= 5'd31;
      count <= count + 32'd1;
    end else if (last_bit) begin
      state <= S_IDLE;
    end else if (busy) begin
      sh <= {sh[WORD_W-2:0], 1'b0};
      bit_cnt <= bit_cnt - 5'd1;
    end
  end
endmodule

// File: rtl/tx_selio_core.sv
// tx_selio_core: AXI4-Lite register front end driving the tx_selio_ser serializer
module tx_selio_core
  import tx_selio_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic                            tx_sdata,
  output logic                            tx_valid,
  output logic                            tx_frame
);
  logic en, loop, pend, underrun, overrun, take, busy, underrun_set, we, tx_wr, st_wr, unused;
  logic [WORD_W-1:0] hold, count, ctrl, status, rd_mux;
  assign we = s00_axi_awready;
  assign s00_axi_wready = s00_axi_awready;
  assign s00_axi_bresp = 2'b00;
  assign s00_axi_rresp = 2'b00;
  assign tx_wr = we && s00_axi_awaddr == ADDR_TXDATA;
  assign st_wr = we && s00_axi_awaddr == ADDR_STATUS && s00_axi_wstrb[0];
  assign unused = ^{s00_axi_awprot, s00_axi_arprot};
  always_comb begin
    ctrl = '0;
    ctrl[CTRL_EN] = en;
    ctrl[CTRL_LOOP] = loop;
    status = '0;
    status[STAT_BUSY] = busy;
    status[STAT_PEND] = pend;
    status[STAT_UNDERRUN] = underrun;
    status[STAT_OVERRUN] = overrun;
    rd_mux = s00_axi_araddr == ADDR_CTRL   ? ctrl   :
             s00_axi_araddr == ADDR_STATUS ? status :
             s00_axi_araddr == ADDR_COUNT  ? count  : '0;
  end
  // a refill landing on the cycle the serializer consumes PEND is a clean handoff, not an overrun
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      s00_axi_awready <= 1'b0;
      s00_axi_bvalid <= 1'b0;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid <= 1'b0;
      s00_axi_rdata <= '0;
      en <= 1'b0;
      loop <= 1'b0;
      pend <= 1'b0;
      underrun <= 1'b0;
      overrun <= 1'b0;
      hold <= '0;
    end else begin
      s00_axi_awready <= ~s00_axi_awready & s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_bvalid;
      s00_axi_bvalid <= we | (s00_axi_bvalid & ~s00_axi_bready);
      s00_axi_arready <= ~s00_axi_arready & s00_axi_arvalid & ~s00_axi_rvalid;
      s00_axi_rvalid <= s00_axi_arready | (s00_axi_rvalid & ~s00_axi_rready);
      if (s00_axi_arready) s00_axi_rdata <= rd_mux;
      if (we && s00_axi_awaddr == ADDR_CTRL && s00_axi_wstrb[0]) begin
        en <= s00_axi_wdata[CTRL_EN];
        loop <= s00_axi_wdata[CTRL_LOOP];
      end
      for (int i = 0; i < WORD_W / 8; i++)
        if (tx_wr && s00_axi_wstrb[i]) hold[8*i +: 8] <= s00_axi_wdata[8*i +: 8];
      pend <= tx_wr | (pend & ~take);
      overrun <= (tx_wr & pend & ~take) | (overrun & ~(st_wr & s00_axi_wdata[STAT_OVERRUN]));
      underrun <= underrun_set | (underrun & ~(st_wr & s00_axi_wdata[STAT_UNDERRUN]));
    end
  end
  tx_selio_ser u_ser (
    .clk(s00_axi_aclk),
    .resetn(s00_axi_aresetn),
    .en(en),
    .loop(loop),
    .pend(pend),
    .hold(hold),
    .take(take),
    .busy(busy),
    .underrun_set(underrun_set),
    .count(count),
    .sdata(tx_sdata),
    .valid(tx_valid),
    .frame(tx_frame)
  );
endmodule

// File: tb/tb_tx_selio_core.sv
// tb_tx_selio_core: scenario tasks with a bit-level scoreboard for the serial output
module tb_tx_selio_core;
  import tx_selio_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic aresetn;
  logic [3:0] awaddr, araddr, wstrb;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [1:0] bresp, rresp;
  logic tx_sdata, tx_valid, tx_frame;
  int checks = 0, failures = 0, cyc = 0, runs_done = 0, run = 0, last_run = 0, first_cyc = 0, hs_cyc = 0;
  logic prev = 1'b0, mon_en = 1'b0;
  logic [1:0] exp_q[$];
  tx_selio_core dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .tx_sdata(tx_sdata), .tx_valid(tx_valid), .tx_frame(tx_frame)
  );
  always @(posedge clk) cyc++;
  // scoreboard: each expected entry is {serial bit, frame flag}
  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_valid) begin
        if (!prev) first_cyc = cyc;
        run++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_bit cyc=%0d sdata=%b frame=%b required no output", cyc, tx_sdata, tx_frame);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          if ({tx_sdata, tx_frame} !== e) begin
            failures++;
            $display("FAIL serial_bit cyc=%0d got sdata=%b frame=%b required sdata=%b frame=%b", cyc, tx_sdata, tx_frame, e[1], e[0]);
          end
        end
      end else begin
        if (prev) begin
          last_run = run;
          run = 0;
          runs_done++;
        end
        checks++;
        if (tx_sdata !== 1'b0 || tx_frame !== 1'b0) begin
          failures++;
          $display("FAIL idle_outputs cyc=%0d sdata=%b frame=%b required 0 0", cyc, tx_sdata, tx_frame);
        end
      end
      prev = tx_valid;
    end
  end
  task automatic push_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) exp_q.push_back({w[i], i == 31});
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    aresetn = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; awprot = '0; arprot = '0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    aresetn = 1'b1;
    mon_en = 1'b1;
  endtask
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!awready && n < 20);
    checks++;
    if (!(awready && wready)) begin
      failures++;
      $display("FAIL write_handshake addr=%h awready=%b wready=%b required 1 1", a, awready, wready);
    end
    hs_cyc = cyc;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      failures++;
      $display("FAIL write_resp addr=%h bvalid=%b bresp=%b required 1 00", a, bvalid, bresp);
    end
    @(posedge clk); #1;
    bready = 1'b0;
  endtask
  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n = 0;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!arready && n < 20);
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    checks++;
    if (rvalid !== 1'b1 || rresp !== 2'b00) begin
      failures++;
      $display("FAIL read_resp addr=%h rvalid=%b rresp=%b required 1 00", a, rvalid, rresp);
    end
    d = rdata;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask
  task automatic wait_runs(input int target);
    int n = 0;
    while (runs_done < target && n < 500) begin @(negedge clk); #1; n++; end
    checks++;
    if (runs_done < target) begin
      failures++;
      $display("FAIL run_timeout runs=%0d required %0d", runs_done, target);
    end
  endtask
  task automatic wait_q(input int sz);
    int n = 0;
    while (exp_q.size() > sz && n < 500) begin @(negedge clk); #1; n++; end
    checks++;
    if (exp_q.size() > sz) begin
      failures++;
      $display("FAIL queue_timeout left=%0d required <=%0d", exp_q.size(), sz);
    end
  endtask
  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    @(negedge clk);
    checks++;
    if ({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata, tx_sdata, tx_valid, tx_frame} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got aw=%b w=%b b=%b ar=%b r=%b rdata=%h tx=%b%b%b required all 0",
               awready, wready, bvalid, arready, rvalid, rdata, tx_sdata, tx_valid, tx_frame);
    end
    axi_read(ADDR_CTRL, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_ctrl got %h required 0", v); end
    axi_read(ADDR_STATUS, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_status got %h required 0", v); end
    axi_read(ADDR_COUNT, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_count got %h required 0", v); end
  endtask
  task automatic test_single();
    logic [31:0] v;
    int rd, h;
    do_reset();
    rd = runs_done;
    axi_write(ADDR_CTRL, 32'h1, 4'hF);
    push_word(32'h0101FFFF);
    axi_write(ADDR_TXDATA, 32'h0101FFFF, 4'hF);
    h = hs_cyc;
    wait_runs(rd + 1);
    checks++; if (first_cyc !== h + 2) begin failures++; $display("FAIL first_bit_latency got cyc %0d required %0d", first_cyc, h + 2); end
    checks++; if (last_run !== 32) begin failures++; $display("FAIL single_run_len got %0d required 32", last_run); end
    axi_read(ADDR_COUNT, v);
    checks++; if (v !== 32'd1) begin failures++; $display("FAIL single_count got %h required 1", v); end
    axi_read(ADDR_TXDATA, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL txdata_read got %h required 0", v); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] v;
    int rd;
    do_reset();
    rd = runs_done;
    axi_write(ADDR_CTRL, 32'h1, 4'hF);
    push_word(32'hABCD0001);
    axi_write(ADDR_TXDATA, 32'hABCD0001, 4'hF);
    push_word(32'hDEAD0011);
    axi_write(ADDR_TXDATA, 32'hDEAD0011, 4'hF);
    wait_q(20);
    axi_write(ADDR_CTRL, 32'h0, 4'hF);
    wait_runs(rd + 1);
    checks++; if (last_run !== 64) begin failures++; $display("FAIL b2b_run_len got %0d required 64", last_run); end
    axi_read(ADDR_COUNT, v);
    checks++; if (v !== 32'd2) begin failures++; $display("FAIL b2b_count got %h required 2", v); end
    axi_read(ADDR_STATUS, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL b2b_status got %h required 0", v); end
  endtask
  task automatic test_underrun();
    logic [31:0] v;
    int rd;
    do_reset();
    rd = runs_done;
    axi_write(ADDR_CTRL, 32'h1, 4'hF);
    push_word(32'hBEEF0011);
    axi_write(ADDR_TXDATA, 32'hBEEF0011, 4'hF);
    axi_read(ADDR_STATUS, v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL busy_status got %h required 1", v); end
    wait_runs(rd + 1);
    checks++; if (last_run !== 32) begin failures++; $display("FAIL underrun_run_len got %0d required 32", last_run); end
    axi_read(ADDR_STATUS, v);
    checks++; if (v !== 32'h4) begin failures++; $display("FAIL underrun_status got %h required 4", v); end
    axi_write(ADDR_STATUS, 32'h4, 4'hF);
    axi_read(ADDR_STATUS, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL underrun_clear got %h required 0", v); end
  endtask
  task automatic test_loop();
    logic [31:0] v;
    int rd;
    do_reset();
    rd = runs_done;
    axi_write(ADDR_CTRL, 32'h3, 4'hF);
    repeat (4) push_word(32'h5);
    axi_write(ADDR_TXDATA, 32'h5, 4'hF);
    wait_q(80);
    axi_read(ADDR_COUNT, v);
    checks++; if (v !== 32'd2) begin failures++; $display("FAIL loop_count2 got %h required 2", v); end
    wait_q(48);
    axi_read(ADDR_COUNT, v);
    checks++; if (v !== 32'd3) begin failures++; $display("FAIL loop_count3 got %h required 3", v); end
    axi_write(ADDR_CTRL, 32'h0, 4'hF);
    wait_runs(rd + 1);
    checks++; if (last_run !== 96) begin failures++; $display("FAIL loop_run_len got %0d required 96", last_run); end
    checks++; if (exp_q.size() !== 32) begin failures++; $display("FAIL loop_stop left=%0d required 32", exp_q.size()); end
    exp_q.delete();
    axi_read(ADDR_STATUS, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL loop_status got %h required 0", v); end
  endtask
  task automatic test_pend_overrun();
    logic [31:0] v;
    int rd;
    do_reset();
    rd = runs_done;
    axi_write(ADDR_TXDATA, 32'h11111111, 4'hF);
    axi_write(ADDR_TXDATA, 32'h22222222, 4'hF);
    axi_read(ADDR_STATUS, v);
    checks++; if (v !== 32'hA) begin failures++; $display("FAIL overrun_status got %h required a", v); end
    push_word(32'h22222222);
    axi_write(ADDR_CTRL, 32'h1, 4'hF);
    wait_runs(rd + 1);
    axi_read(ADDR_COUNT, v);
    checks++; if (v !== 32'd1) begin failures++; $display("FAIL overrun_count got %h required 1", v); end
    axi_read(ADDR_STATUS, v);
    checks++; if (v !== 32'hC) begin failures++; $display("FAIL overrun_end_status got %h required c", v); end
  endtask
  task automatic test_reset_mid();
    logic [31:0] v;
    do_reset();
    axi_write(ADDR_CTRL, 32'h1, 4'hF);
    push_word(32'h12345678);
    axi_write(ADDR_TXDATA, 32'h12345678, 4'hF);
    wait_q(16);
    @(posedge clk); #1;
    aresetn = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, rdata, tx_sdata, tx_valid, tx_frame} !== '0) begin
      failures++;
      $display("FAIL midword_reset got valid=%b sdata=%b frame=%b rdata=%h required all 0", tx_valid, tx_sdata, tx_frame, rdata);
    end
    exp_q.delete();
    @(posedge clk); #1;
    aresetn = 1'b1;
    repeat (40) @(negedge clk);
    axi_read(ADDR_STATUS, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL midword_status got %h required 0", v); end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_loop();
    test_pend_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
